// File: rtl/bram_arb_pkg.sv
// Shared constants for the BRAM port arbiter: arbitration modes, FSM encoding
// and the width helpers used to size indices and aging counters.
package bram_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // A single-port arbiter still carries a one-bit index so no vector collapses to zero width.
    function automatic int idx_width(input int num);
        return (num > 1) ? clog2(num) : 1;
    endfunction

endpackage

// File: rtl/bram_arb_picker.sv
// Combinational winner selection: promoted ports first (lowest index), otherwise
// the first requester found searching upward from the start pointer with wrap.
module bram_arb_picker
    import bram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int IDX_W = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] promoted,
    input  logic [IDX_W-1:0]     start,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic [NUM_PORTS-1:0] rotated;
    logic [IDX_W:0]       wrapped;
    logic                 found;

    always_comb begin
        rotated   = NUM_PORTS'({req, req} >> start);
        grant_idx = '0;
        wrapped   = '0;
        found     = 1'b0;
        if (|promoted) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && promoted[i]) begin
                    found     = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && rotated[k]) begin
                    found   = 1'b1;
                    wrapped = {1'b0, start} + (IDX_W+1)'(k);
                    if (wrapped >= (IDX_W+1)'(NUM_PORTS))
                        wrapped = wrapped - (IDX_W+1)'(NUM_PORTS);
                    grant_idx = wrapped[IDX_W-1:0];
                end
            end
        end
        grant = found ? (NUM_PORTS'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// N-port arbiter sharing one line-wide BRAM; each grant is locked for the whole
// IDLE-BUSY-RESP access, with fixed-priority aging or round-robin selection.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_BITS    = 15,
    parameter int DATA_BITS    = 128,
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4,
    localparam int IDX_W = idx_width(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           port_req,
    input  logic [NUM_PORTS-1:0]           port_write,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_BITS-1:0] port_wdata,
    output logic [DATA_BITS-1:0]           port_rdata,
    output logic [NUM_PORTS-1:0]           port_valid,
    output logic                           mem_req,
    output logic                           mem_write,
    output logic [ADDR_BITS-1:0]           mem_addr,
    output logic [DATA_BITS-1:0]           mem_wdata,
    input  logic [DATA_BITS-1:0]           mem_rdata,
    input  logic                           mem_valid,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           busy
);

    localparam int              AGE_W    = (STARVE_LIMIT > 0) ? clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);
    localparam bit              AGING_ON = (ARB_MODE == ARB_FIXED) && (STARVE_LIMIT > 0);

    logic [1:0]           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     pick_start;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic [IDX_W:0]       ptr_inc;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [NUM_PORTS-1:0] promoted;
    logic [AGE_W-1:0]     age [NUM_PORTS];
    logic [ADDR_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0] sel_wdata;
    logic                 sel_write;

    assign busy       = (state == ST_BUSY) || (state == ST_RESP);
    assign pick_start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

    bram_arb_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req       (port_req),
        .promoted  (promoted),
        .start     (pick_start),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // Promotion only counts for a port that is still asking at the decision.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        promoted  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            promoted[i] = AGING_ON && port_req[i] && (age[i] == AGE_MAX);
            if (pick_grant[i]) begin
                sel_addr  = port_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_wdata = port_wdata[i*DATA_BITS +: DATA_BITS];
                sel_write = port_write[i];
            end
        end
    end

    always_comb begin
        ptr_inc  = {1'b0, pick_idx} + 1'b1;
        next_ptr = (ptr_inc == (IDX_W+1)'(NUM_PORTS)) ? '0 : ptr_inc[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            port_rdata <= '0;
            port_valid <= '0;
            grant_id   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) age[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|port_req) begin
                        mem_req   <= 1'b1;
                        mem_write <= sel_write;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        grant_id  <= pick_idx;
                        state     <= ST_BUSY;
                        if (ARB_MODE == ARB_RR) rr_ptr <= next_ptr;
                    end
                    if (AGING_ON) begin
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            if (!port_req[i] || pick_grant[i])
                                age[i] <= '0;
                            else if (age[i] != AGE_MAX)
                                age[i] <= age[i] + 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_valid) begin
                        port_rdata <= mem_rdata;
                        mem_req    <= 1'b0;
                        mem_write  <= 1'b0;
                        port_valid <= NUM_PORTS'(1) << grant_id;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    port_valid <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: fixed-priority and round-robin 4-port instances
// plus a single-port instance, checked against a transaction-level model.
module tb_bram_port_arbiter;

    localparam int NP    = 4;
    localparam int AB    = 15;
    localparam int DB    = 128;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // index 0: fixed priority with aging, index 1: round-robin
    logic [NP-1:0]    req   [2];
    logic [NP-1:0]    wr    [2];
    logic [NP*AB-1:0] addr  [2];
    logic [NP*DB-1:0] wdata [2];
    logic [DB-1:0]    rdata_o [2];
    logic [NP-1:0]    pv    [2];
    logic             mreq  [2];
    logic             mwr   [2];
    logic [AB-1:0]    maddr [2];
    logic [DB-1:0]    mwd   [2];
    logic [DB-1:0]    mrd   [2];
    logic             mval  [2];
    logic [1:0]       gid   [2];
    logic             busy_o [2];

    logic          s_req, s_wr, s_pv, s_mreq, s_mwr, s_mval, s_gid, s_busy;
    logic [AB-1:0] s_addr, s_maddr;
    logic [DB-1:0] s_wd, s_rdata, s_mwd, s_mrd;

    int checks = 0;
    int errors = 0;
    int age_m [NP];
    int ptr_m;

    bram_port_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .ARB_MODE(0), .STARVE_LIMIT(LIMIT)) u_fix (
        .clk(clk), .rst(rst), .port_req(req[0]), .port_write(wr[0]), .port_addr(addr[0]),
        .port_wdata(wdata[0]), .port_rdata(rdata_o[0]), .port_valid(pv[0]), .mem_req(mreq[0]),
        .mem_write(mwr[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]),
        .mem_valid(mval[0]), .grant_id(gid[0]), .busy(busy_o[0]));

    bram_port_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .ARB_MODE(1), .STARVE_LIMIT(LIMIT)) u_rr (
        .clk(clk), .rst(rst), .port_req(req[1]), .port_write(wr[1]), .port_addr(addr[1]),
        .port_wdata(wdata[1]), .port_rdata(rdata_o[1]), .port_valid(pv[1]), .mem_req(mreq[1]),
        .mem_write(mwr[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]),
        .mem_valid(mval[1]), .grant_id(gid[1]), .busy(busy_o[1]));

    bram_port_arbiter #(.NUM_PORTS(1), .ADDR_BITS(AB), .DATA_BITS(DB), .ARB_MODE(0), .STARVE_LIMIT(LIMIT)) u_one (
        .clk(clk), .rst(rst), .port_req(s_req), .port_write(s_wr), .port_addr(s_addr),
        .port_wdata(s_wd), .port_rdata(s_rdata), .port_valid(s_pv), .mem_req(s_mreq),
        .mem_write(s_mwr), .mem_addr(s_maddr), .mem_wdata(s_mwd), .mem_rdata(s_mrd),
        .mem_valid(s_mval), .grant_id(s_gid), .busy(s_busy));

    function automatic logic [DB-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference choice: fixed = promoted ports first, else lowest index; RR = first from ptr.
    function automatic int model_pick(input int d, input logic [NP-1:0] p);
        if (d == 0) begin
            for (int i = 0; i < NP; i++) if (p[i] && age_m[i] == LIMIT) return i;
            for (int i = 0; i < NP; i++) if (p[i]) return i;
        end else begin
            for (int k = 0; k < NP; k++) if (p[(ptr_m + k) % NP]) return (ptr_m + k) % NP;
        end
        return 0;
    endfunction

    task automatic model_update(input int d, input logic [NP-1:0] p, input int w);
        if (d == 0) begin
            for (int i = 0; i < NP; i++)
                age_m[i] = (p[i] && i != w) ? ((age_m[i] < LIMIT) ? age_m[i] + 1 : LIMIT) : 0;
        end else begin
            ptr_m = (w + 1) % NP;
        end
    endtask

    task automatic new_request(input int d, input int i);
        req[d][i]            = 1'b1;
        wr[d][i]             = 1'($urandom_range(0, 1));
        addr[d][i*AB +: AB]  = AB'($urandom());
        wdata[d][i*DB +: DB] = rnd128();
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; wr[d] = '0; addr[d] = '0; wdata[d] = '0; mrd[d] = '0; mval[d] = 1'b0;
        end
        s_req = 1'b0; s_wr = 1'b0; s_addr = '0; s_wd = '0; s_mrd = '0; s_mval = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NP; i++) age_m[i] = 0;
        ptr_m = 0;
    endtask

    // One locked access starting from IDLE; returns model winner w and DUT grant_id g.
    task automatic run_txn(input int d, input int lat, input logic [DB-1:0] rd,
                           input logic [NP-1:0] late, input bit drop, output int w, output int g);
        logic [NP-1:0] p;
        logic [AB-1:0] ea;
        logic [DB-1:0] ewd;
        logic          ewr;
        p   = req[d];
        w   = model_pick(d, p);
        model_update(d, p, w);
        ea  = addr[d][w*AB +: AB];
        ewd = wdata[d][w*DB +: DB];
        ewr = wr[d][w];
        @(posedge clk); #1;
        g = int'(gid[d]);
        checks++;
        if (mreq[d] !== 1'b1 || busy_o[d] !== 1'b1) begin
            errors++; $display("FAIL start[%0d]: mem_req=%b busy=%b, want 1 1", d, mreq[d], busy_o[d]);
        end
        checks++;
        if (gid[d] !== 2'(w)) begin
            errors++; $display("FAIL grant_id[%0d]: got %0d, want %0d", d, gid[d], w);
        end
        checks++;
        if (maddr[d] !== ea || mwr[d] !== ewr || mwd[d] !== ewd) begin
            errors++; $display("FAIL mem_cmd[%0d]: addr %h write %b, want addr %h write %b (or wdata)", d, maddr[d], mwr[d], ea, ewr);
        end
        for (int i = 0; i < NP; i++) if (late[i] && !req[d][i]) new_request(d, i);
        if (drop) req[d][w] = 1'b0;
        repeat (lat) begin
            @(posedge clk); #1;
            checks++;
            if (mreq[d] !== 1'b1 || pv[d] !== '0 || maddr[d] !== ea) begin
                errors++; $display("FAIL hold[%0d]: mem_req=%b valid=%b addr=%h, want 1 0 %h", d, mreq[d], pv[d], maddr[d], ea);
            end
        end
        mrd[d]  = rd;
        mval[d] = 1'b1;
        @(posedge clk); #1;
        mval[d] = 1'b0;
        checks++;
        if (pv[d] !== NP'(1 << w) || rdata_o[d] !== rd || mreq[d] !== 1'b0 || mwr[d] !== 1'b0 || busy_o[d] !== 1'b1) begin
            errors++; $display("FAIL resp[%0d]: valid=%b rdata=%h mem_req=%b, want valid=%b rdata=%h mem_req=0", d, pv[d], rdata_o[d], mreq[d], NP'(1 << w), rd);
        end
        req[d][w] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pv[d] !== '0 || busy_o[d] !== 1'b0 || mreq[d] !== 1'b0) begin
            errors++; $display("FAIL idle[%0d]: valid=%b busy=%b mem_req=%b, want 0 0 0", d, pv[d], busy_o[d], mreq[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        req[0] = 4'b1111; req[1] = 4'b1111; s_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({rdata_o[d], pv[d], mreq[d], mwr[d], maddr[d], mwd[d], gid[d], busy_o[d]} !== '0) begin
                errors++; $display("FAIL reset_outputs[%0d]: mem_req=%b valid=%b busy=%b gid=%0d, want all 0", d, mreq[d], pv[d], busy_o[d], gid[d]);
            end
        end
        checks++;
        if ({s_rdata, s_pv, s_mreq, s_mwr, s_maddr, s_mwd, s_gid, s_busy} !== '0) begin
            errors++; $display("FAIL reset_outputs_single: mem_req=%b valid=%b busy=%b, want all 0", s_mreq, s_pv, s_busy);
        end
        do_reset();
    endtask

    task automatic test_fixed_pair();
        int w, g;
        do_reset();
        new_request(0, 0); new_request(0, 1);
        run_txn(0, 2, rnd128(), '0, 1'b0, w, g);
        checks++;
        if (g != 0) begin errors++; $display("FAIL fixed_first: grant %0d, want 0", g); end
        run_txn(0, 2, rnd128(), '0, 1'b0, w, g);
        checks++;
        if (g != 1) begin errors++; $display("FAIL fixed_second: grant %0d, want 1", g); end
    endtask

    task automatic test_rr_alternate();
        int w, g;
        do_reset();
        new_request(1, 0); new_request(1, 1);
        for (int k = 0; k < 4; k++) begin
            run_txn(1, 1, rnd128(), '0, 1'b0, w, g);
            checks++;
            if (g != k % 2) begin errors++; $display("FAIL rr_alternate: step %0d grant %0d, want %0d", k, g, k % 2); end
            new_request(1, w);
        end
    endtask

    task automatic test_starvation();
        int w, g;
        do_reset();
        new_request(0, 0); new_request(0, 1);
        for (int k = 0; k < 10; k++) begin
            run_txn(0, 0, rnd128(), '0, 1'b0, w, g);
            checks++;
            if (g != ((k % 5 == 4) ? 1 : 0)) begin
                errors++; $display("FAIL starvation: decision %0d grant %0d, want %0d", k + 1, g, (k % 5 == 4) ? 1 : 0);
            end
            new_request(0, w);
        end
    endtask

    task automatic test_no_preempt();
        int w, g;
        do_reset();
        new_request(0, 1);
        run_txn(0, 1, {16{8'hA5}}, 4'b0001, 1'b0, w, g);
        checks++;
        if (g != 1) begin errors++; $display("FAIL no_preempt_owner: grant %0d, want 1", g); end
        run_txn(0, 0, rnd128(), '0, 1'b0, w, g);
        checks++;
        if (g != 0) begin errors++; $display("FAIL no_preempt_waiter: grant %0d, want 0", g); end
    endtask

    task automatic test_async_reset();
        int w, g;
        do_reset();
        new_request(1, 0);
        run_txn(1, 0, rnd128(), '0, 1'b0, w, g);
        new_request(1, 1);
        @(posedge clk); #1;
        checks++;
        if (mreq[1] !== 1'b1 || gid[1] !== 2'd1) begin
            errors++; $display("FAIL pre_reset_busy: mem_req=%b gid=%0d, want 1 1", mreq[1], gid[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mreq[1] !== 1'b0 || pv[1] !== '0 || busy_o[1] !== 1'b0) begin
            errors++; $display("FAIL async_reset: mem_req=%b valid=%b busy=%b, want 0 0 0", mreq[1], pv[1], busy_o[1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        ptr_m = 0;
        for (int i = 0; i < NP; i++) age_m[i] = 0;
        new_request(1, 0); new_request(1, 3);
        run_txn(1, 0, rnd128(), '0, 1'b0, w, g);
        checks++;
        if (g != 0) begin errors++; $display("FAIL ptr_after_reset: grant %0d, want 0", g); end
    endtask

    task automatic test_rr4_wrap();
        int w, g;
        do_reset();
        new_request(1, 0);
        run_txn(1, 0, rnd128(), '0, 1'b0, w, g);
        new_request(1, 0); new_request(1, 3);
        run_txn(1, 1, rnd128(), '0, 1'b0, w, g);
        checks++;
        if (g != 3) begin errors++; $display("FAIL rr_wrap_first: grant %0d, want 3", g); end
        run_txn(1, 1, rnd128(), '0, 1'b0, w, g);
        checks++;
        if (g != 0) begin errors++; $display("FAIL rr_wrap_second: grant %0d, want 0", g); end
    endtask

    task automatic test_protocol_violation();
        int w, g;
        do_reset();
        new_request(0, 2);
        run_txn(0, 1, rnd128(), '0, 1'b1, w, g);
        checks++;
        if (g != 2) begin errors++; $display("FAIL dropped_req: grant %0d, want 2", g); end
    endtask

    task automatic test_stray_valid();
        logic [DB-1:0] rd;
        do_reset();
        mval[0] = 1'b1; mrd[0] = rnd128();
        @(posedge clk); #1;
        checks++;
        if (pv[0] !== '0 || busy_o[0] !== 1'b0 || rdata_o[0] !== '0) begin
            errors++; $display("FAIL stray_idle: valid=%b busy=%b, want 0 0", pv[0], busy_o[0]);
        end
        mval[0] = 1'b0;
        new_request(0, 0);
        @(posedge clk); #1;
        rd = rnd128();
        mval[0] = 1'b1; mrd[0] = rd;
        @(posedge clk); #1;
        req[0][0] = 1'b0;
        mrd[0] = ~rd;
        @(posedge clk); #1;
        mval[0] = 1'b0;
        checks++;
        if (pv[0] !== '0 || busy_o[0] !== 1'b0 || rdata_o[0] !== rd) begin
            errors++; $display("FAIL stray_resp: valid=%b busy=%b rdata=%h, want 0 0 %h", pv[0], busy_o[0], rdata_o[0], rd);
        end
    endtask

    task automatic test_single_port();
        logic [DB-1:0] rd;
        do_reset();
        rd = rnd128();
        s_req = 1'b1; s_wr = 1'b1; s_addr = AB'($urandom()); s_wd = rnd128();
        #1;
        checks++;
        if (s_mreq !== 1'b0) begin errors++; $display("FAIL single_early: mem_req=%b, want 0", s_mreq); end
        @(posedge clk); #1;
        checks++;
        if (s_mreq !== 1'b1 || s_gid !== 1'b0 || s_maddr !== s_addr || s_mwr !== 1'b1 || s_mwd !== s_wd || s_busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: mem_req=%b addr=%h, want 1 %h", s_mreq, s_maddr, s_addr);
        end
        s_mval = 1'b1; s_mrd = rd;
        @(posedge clk); #1;
        s_mval = 1'b0;
        checks++;
        if (s_pv !== 1'b1 || s_rdata !== rd || s_mreq !== 1'b0) begin
            errors++; $display("FAIL single_resp: valid=%b rdata=%h, want 1 %h", s_pv, s_rdata, rd);
        end
        s_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_pv !== 1'b0 || s_busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: valid=%b busy=%b, want 0 0", s_pv, s_busy);
        end
    endtask

    task automatic test_random(input int d);
        int w, g;
        logic [NP-1:0] late;
        do_reset();
        for (int i = 0; i < NP; i++) if ($urandom_range(0, 1) == 1) new_request(d, i);
        if (req[d] == '0) new_request(d, $urandom_range(0, NP - 1));
        repeat (40) begin
            late = NP'($urandom()) & ~req[d];
            if ($urandom_range(0, 1) == 0) late = '0;
            run_txn(d, $urandom_range(0, 3), rnd128(), late, 1'b0, w, g);
            for (int i = 0; i < NP; i++) if (!req[d][i] && $urandom_range(0, 2) != 0) new_request(d, i);
            if (req[d] == '0) new_request(d, $urandom_range(0, NP - 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fixed_pair();
        test_rr_alternate();
        test_starvation();
        test_no_preempt();
        test_async_reset();
        test_rr4_wrap();
        test_protocol_violation();
        test_stray_valid();
        test_single_port();
        test_random(0);
        test_random(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
